i2c_target_m24c16: RTL and testbench

- Synchronous I2C responder (target) that emulates the bus side of an M24C16-style 16 Kbit serial EEPROM.
- Decodes START/STOP, device-select, word-address and data bytes from oversampled SCL/SDA, and drives SDA open-drain for ACK and read data.
- Accesses an external 2048x8 storage through a simple memory port.
- Used as a loop-back target for the I2C bit-bang initiator in bench and self-test bitstreams.

---
 rtl/i2c_target_m24c16.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_target_m24c16.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_m24c16.sv
// M24C16-style I2C EEPROM target: bus decode, open-drain SDA, memory port.
// Storage lives outside; reads prefetch one byte ahead of the SCL falls.
module i2c_target_m24c16 #(
  parameter logic [3:0] DEV_TYPE    = 4'b1010,
  parameter int         PAGE_BITS   = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out_en,
  input  logic        wc_n,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEVSEL, S_ACK, S_WADDR,
    S_WDATA, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  state_t                 r_state;
  state_t                 r_ret;
  logic [3:0]             r_cnt;
  logic [7:0]             r_shift;
  logic [10:0]            r_ptr;
  logic                   r_ack_ph;
  logic                   r_ack_drv;
  logic                   r_commit;
  logic                   r_wen;
  logic                   r_pf;
  logic [1:0]             r_ld;
  logic                   r_sda_oe;
  logic                   r_we;
  logic [10:0]            r_addr;
  logic [7:0]             r_wdata;

  logic                 w_scl;
  logic                 w_sda;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_start;
  logic                 w_stop;
  logic                 w_last;
  logic [7:0]           w_byte;
  logic [PAGE_BITS-1:0] w_pg;

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  // SCL must be high on both samples, so an SCL edge masks START/STOP
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_last  = (r_cnt == 4'd7);
  assign w_byte  = {r_shift[6:0], w_sda};
  assign w_pg    = r_ptr[PAGE_BITS-1:0] + PAGE_BITS'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_ret      <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_ack_ph   <= 1'b0;
      r_ack_drv  <= 1'b0;
      r_commit   <= 1'b0;
      r_wen      <= 1'b0;
      r_pf       <= 1'b0;
      r_ld       <= '0;
      r_sda_oe   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_we       <= 1'b0;
      r_commit   <= 1'b0;
      r_ld       <= {r_ld[0], r_pf};
      if (r_pf) begin
        r_pf   <= 1'b0;
        r_addr <= r_ptr;
      end
      if (r_ld[1]) r_shift <= mem_rdata;
      if (r_commit) begin
        if (r_wen) begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= r_shift;
        end
        r_ptr <= {r_ptr[10:PAGE_BITS], w_pg};
      end
      if (w_start) begin
        r_state  <= S_DEVSEL;
        r_cnt    <= '0;
        r_sda_oe <= 1'b0;
        r_ack_ph <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_ack_ph <= 1'b0;
      end else begin
        unique case (r_state)
          S_DEVSEL: if (w_rise) begin
            r_shift <= w_byte;
            r_cnt   <= r_cnt + 4'd1;
            if (w_last) begin
              r_cnt <= '0;
              if (w_byte[7:4] == DEV_TYPE) begin
                r_ptr[10:8] <= w_byte[3:1];
                r_state     <= S_ACK;
                r_ack_drv   <= 1'b1;
                r_ret       <= w_byte[0] ? S_RDATA : S_WADDR;
                r_pf        <= w_byte[0];
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          S_WADDR: if (w_rise) begin
            r_shift <= w_byte;
            r_cnt   <= r_cnt + 4'd1;
            if (w_last) begin
              r_cnt      <= '0;
              r_ptr[7:0] <= w_byte;
              r_state    <= S_ACK;
              r_ack_drv  <= 1'b1;
              r_ret      <= S_WDATA;
            end
          end
          S_WDATA: if (w_rise) begin
            r_shift <= w_byte;
            r_cnt   <= r_cnt + 4'd1;
            if (w_last) begin
              r_cnt     <= '0;
              r_commit  <= 1'b1;
              r_wen     <= wc_n;
              r_ack_drv <= wc_n;
              r_state   <= S_ACK;
              r_ret     <= S_WDATA;
            end
          end
          S_ACK: if (w_fall) begin
            if (!r_ack_ph) begin
              r_sda_oe <= r_ack_drv;
              r_ack_ph <= 1'b1;
            end else begin
              r_ack_ph <= 1'b0;
              r_state  <= r_ret;
              r_cnt    <= '0;
              r_sda_oe <= 1'b0;
              // the fall that ends the ACK also presents read bit 7
              if (r_ret == S_RDATA) begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_cnt    <= 4'd1;
              end
            end
          end
          S_RDATA: if (w_fall) begin
            if (r_cnt == 4'd8) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_RDATA_ACK;
            end else begin
              r_sda_oe <= ~r_shift[7];
              r_shift  <= {r_shift[6:0], 1'b0};
              r_cnt    <= r_cnt + 4'd1;
            end
          end
          S_RDATA_ACK: if (w_rise) begin
            r_ptr <= r_ptr + 11'd1;
            if (!w_sda) begin
              r_pf    <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_RDATA;
            end else begin
              r_state <= S_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_out_en = r_sda_oe;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_we;
  assign busy       = (r_state != S_IDLE) && (r_state != S_IGNORE);

endmodule

// File: tb/tb_i2c_target_m24c16.sv
// Directed bench for i2c_target_m24c16: bit-banged master plus
// a 2048x8 registered memory model with a write log.
module tb_i2c_target_m24c16;

  localparam int Q = 16;

  logic        clk;
  logic        rst;
  logic        scl;
  logic        sda_m;
  logic        sda_bus;
  logic        sda_out_en;
  logic        wc_n;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic [7:0]  mem [0:2047];
  logic        pre_we;
  logic [10:0] pre_a;
  logic [7:0]  pre_d;
  logic [10:0] wa [$];
  logic [7:0]  wd [$];
  int          drv_n;
  int          n_chk;
  int          n_err;

  assign sda_bus = sda_m & ~sda_out_en;

  i2c_target_m24c16 dut (
    .clock      (clk),
    .reset      (rst),
    .scl_in     (scl),
    .sda_in     (sda_bus),
    .sda_out_en (sda_out_en),
    .wc_n       (wc_n),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial drv_n = 0;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (pre_we) mem[pre_a] <= pre_d;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (sda_out_en) drv_n <= drv_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    tick(1);
    pre_we = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(Q);
      scl = 1'b1; tick(2 * Q);
      scl = 1'b0; tick(Q);
    end
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    ack = ~sda_bus; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      tick(Q);
      scl = 1'b1; tick(Q);
      b = {b[6:0], sda_bus}; tick(Q);
      scl = 1'b0; tick(Q);
    end
    sda_m = nack; tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
    sda_m = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    n_chk++; if (sda_out_en !== 1'b0) begin n_err++; $display("FAIL rst_oe got=%b exp=0", sda_out_en); end
    n_chk++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b exp=0", mem_we); end
    n_chk++; if (mem_addr !== 11'h000) begin n_err++; $display("FAIL rst_addr got=%h exp=000", mem_addr); end
    n_chk++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL rst_wdata got=%h exp=00", mem_wdata); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_byte_write();
    logic a0, a1, a2;
    int base;
    base = wa.size();
    wc_n = 1'b1;
    i2c_start();
    wr_byte(8'hA4, a0);
    n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL bw_busy_mid got=%b exp=1", busy); end
    wr_byte(8'h37, a1);
    wr_byte(8'h5A, a2);
    i2c_stop();
    tick(8);
    n_chk++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL bw_acks got=%b exp=111", {a0, a1, a2}); end
    n_chk++; if (wa.size() - base != 1) begin n_err++; $display("FAIL bw_count got=%0d exp=1", wa.size() - base); end
    else begin
      n_chk++; if (wa[base] !== 11'h237) begin n_err++; $display("FAIL bw_addr got=%h exp=237", wa[base]); end
      n_chk++; if (wd[base] !== 8'h5A) begin n_err++; $display("FAIL bw_data got=%h exp=5a", wd[base]); end
    end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL bw_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_page_wrap();
    logic [10:0] ea [3];
    logic [7:0]  ed [3];
    logic a0, a1, a2, a3, a4;
    int base;
    ea = '{11'h01E, 11'h01F, 11'h010};
    ed = '{8'h11, 8'h22, 8'h33};
    base = wa.size();
    i2c_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h1E, a1);
    wr_byte(8'h11, a2);
    wr_byte(8'h22, a3);
    wr_byte(8'h33, a4);
    i2c_stop();
    tick(8);
    n_chk++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin n_err++; $display("FAIL pw_acks got=%b exp=11111", {a0, a1, a2, a3, a4}); end
    n_chk++; if (wa.size() - base != 3) begin n_err++; $display("FAIL pw_count got=%0d exp=3", wa.size() - base); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (wa[base+i] !== ea[i]) begin n_err++; $display("FAIL pw_addr%0d got=%h exp=%h", i, wa[base+i], ea[i]); end
        n_chk++; if (wd[base+i] !== ed[i]) begin n_err++; $display("FAIL pw_data%0d got=%h exp=%h", i, wd[base+i], ed[i]); end
      end
    end
  endtask

  task automatic test_random_read();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] b0, b1, b2, b3;
    int base;
    preload(11'h3FF, 8'hC3);
    preload(11'h400, 8'h96);
    preload(11'h300, 8'hA5);
    preload(11'h7FF, 8'h3C);
    preload(11'h000, 8'h69);
    base = wa.size();
    i2c_start();
    wr_byte(8'hA6, a0);
    wr_byte(8'hFF, a1);
    i2c_start();
    wr_byte(8'hA7, a2);
    rd_byte(1'b0, b0);
    rd_byte(1'b1, b1);
    i2c_stop();
    n_chk++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL rr_acks got=%b exp=111", {a0, a1, a2}); end
    n_chk++; if (b0 !== 8'hC3) begin n_err++; $display("FAIL rr_byte0 got=%h exp=c3", b0); end
    n_chk++; if (b1 !== 8'h96) begin n_err++; $display("FAIL rr_byte1 got=%h exp=96", b1); end
    i2c_start();
    wr_byte(8'hAE, a3);
    wr_byte(8'hFF, a4);
    i2c_start();
    wr_byte(8'hAF, a5);
    rd_byte(1'b0, b2);
    rd_byte(1'b1, b3);
    i2c_stop();
    tick(8);
    n_chk++; if ({a3, a4, a5} !== 3'b111) begin n_err++; $display("FAIL rw_acks got=%b exp=111", {a3, a4, a5}); end
    n_chk++; if (b2 !== 8'h3C) begin n_err++; $display("FAIL rw_byte7ff got=%h exp=3c", b2); end
    n_chk++; if (b3 !== 8'h69) begin n_err++; $display("FAIL rw_byte000 got=%h exp=69", b3); end
    n_chk++; if (wa.size() != base) begin n_err++; $display("FAIL rr_nowrite got=%0d exp=%0d", wa.size(), base); end
  endtask

  task automatic test_write_protect();
    logic a0, a1, a2;
    int base;
    base = wa.size();
    wc_n = 1'b0;
    i2c_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h10, a1);
    wr_byte(8'hEE, a2);
    i2c_stop();
    tick(8);
    wc_n = 1'b1;
    n_chk++; if ({a0, a1, a2} !== 3'b110) begin n_err++; $display("FAIL wp_acks got=%b exp=110", {a0, a1, a2}); end
    n_chk++; if (wa.size() != base) begin n_err++; $display("FAIL wp_nowrite got=%0d exp=%0d", wa.size(), base); end
  endtask

  task automatic test_wrong_device();
    logic a0, a1;
    logic [7:0] b0;
    int d0;
    preload(11'h011, 8'h4B);
    d0 = drv_n;
    i2c_start();
    wr_byte(8'h50, a0);
    n_chk++; if (a0 !== 1'b0) begin n_err++; $display("FAIL wd_nack got=%b exp=0", a0); end
    n_chk++; if (drv_n != d0) begin n_err++; $display("FAIL wd_nodrive got=%0d exp=%0d", drv_n, d0); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL wd_busy got=%b exp=0", busy); end
    i2c_start();
    wr_byte(8'hA1, a1);
    rd_byte(1'b1, b0);
    i2c_stop();
    n_chk++; if (a1 !== 1'b1) begin n_err++; $display("FAIL wd_ack2 got=%b exp=1", a1); end
    n_chk++; if (b0 !== 8'h4B) begin n_err++; $display("FAIL wd_read got=%h exp=4b", b0); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3;
    int base;
    preload(11'h012, 8'h00);
    i2c_start();
    wr_byte(8'hA1, a0);
    n_chk++; if (sda_out_en !== 1'b1) begin n_err++; $display("FAIL rm_driving got=%b exp=1", sda_out_en); end
    rst = 1'b1;
    tick(1);
    n_chk++; if (sda_out_en !== 1'b0) begin n_err++; $display("FAIL rm_release got=%b exp=0", sda_out_en); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick(4);
    base = wa.size();
    i2c_start();
    wr_byte(8'hA0, a1);
    wr_byte(8'h40, a2);
    wr_byte(8'h77, a3);
    i2c_stop();
    tick(8);
    n_chk++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_err++; $display("FAIL rm_acks got=%b exp=1111", {a0, a1, a2, a3}); end
    n_chk++; if (wa.size() - base != 1) begin n_err++; $display("FAIL rm_count got=%0d exp=1", wa.size() - base); end
    else begin
      n_chk++; if (wa[base] !== 11'h040) begin n_err++; $display("FAIL rm_addr got=%h exp=040", wa[base]); end
      n_chk++; if (wd[base] !== 8'h77) begin n_err++; $display("FAIL rm_data got=%h exp=77", wd[base]); end
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    scl = 1'b1;
    sda_m = 1'b1;
    wc_n = 1'b1;
    pre_we = 1'b0;
    pre_a = '0;
    pre_d = '0;
    test_reset();
    test_byte_write();
    test_page_wrap();
    test_random_read();
    test_write_protect();
    test_wrong_device();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
